// File: rtl/axis_packet_arbiter_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter: FSM encoding,
// sizing helper and the round-robin pick used by the arbitration decision.
package axis_packet_arbiter_pkg;

  typedef enum logic {
    ArbStateIdle   = 1'b0,
    ArbStateLocked = 1'b1
  } arb_state_e;

  localparam int unsigned MaxRequesters = 16;
  localparam int unsigned MaxGrantWidth = 4;

  // Width of an index able to address n items, never below one bit.
  function automatic int unsigned bitsize(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set request at or above ptr, wrapping at n; ptr is assumed < n.
  function automatic logic [MaxGrantWidth-1:0] rr_pick(
    input logic [MaxRequesters-1:0] req,
    input logic [MaxGrantWidth-1:0] ptr,
    input int unsigned              n
  );
    logic [MaxGrantWidth:0] idx;
    logic                   found;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < MaxRequesters; i++) begin
      idx = 5'(ptr) + 5'(i);
      if (idx >= 5'(n)) begin
        idx = idx - 5'(n);
      end
      if (!found && (i < n) && req[idx[MaxGrantWidth-1:0]]) begin
        rr_pick = idx[MaxGrantWidth-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream output register stage; outputs come straight from the
// head register, and the producer is told one cycle ahead whether space remains.
module axis_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  output logic             not_full_next_c,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  logic [Width-1:0] head_q, head_d, tail_q, tail_d;
  logic             head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic             pop_c;

  assign pop_c     = head_vld_q && out_ready;
  assign out_valid = head_vld_q;
  assign out_data  = head_q;

  // Pop shifts tail into head first, then a push fills the first empty slot.
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;
    if (pop_c) begin
      head_d     = tail_q;
      head_vld_d = tail_vld_q;
      tail_vld_d = 1'b0;
    end
    if (push) begin
      if (!head_vld_d) begin
        head_d     = push_data;
        head_vld_d = 1'b1;
      end else begin
        tail_d     = push_data;
        tail_vld_d = 1'b1;
      end
    end
    not_full_next_c = !tail_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream initiator among
// several sources; grant is held from first beat until tlast is accepted.
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned TDataWidth    = 64,
  parameter int unsigned TIdWidth      = 8,
  parameter int unsigned TDestWidth    = 8,
  parameter int unsigned TidOverride   = 0
) (
  input  logic                                clk_m_axis_i,
  input  logic                                rst_m_axis_i,
  input  logic [NumRequesters-1:0]            s_axis_tvalid_i,
  output logic [NumRequesters-1:0]            s_axis_tready_o,
  input  logic [NumRequesters*TDataWidth-1:0] s_axis_tdata_i,
  input  logic [NumRequesters-1:0]            s_axis_tlast_i,
  input  logic [NumRequesters*TIdWidth-1:0]   s_axis_tid_i,
  input  logic [NumRequesters*TDestWidth-1:0] s_axis_tdest_i,
  output logic                                m_axis_tvalid_o,
  input  logic                                m_axis_tready_i,
  output logic [TDataWidth-1:0]               m_axis_tdata_o,
  output logic                                m_axis_tlast_o,
  output logic [TIdWidth-1:0]                 m_axis_tid_o,
  output logic [TDestWidth-1:0]               m_axis_tdest_o,
  output logic [bitsize(NumRequesters)-1:0]   grant_o,
  output logic                                busy_o
);

  localparam int unsigned GrantWidth   = bitsize(NumRequesters);
  localparam int unsigned PayloadWidth = TDataWidth + 1 + TIdWidth + TDestWidth;

  arb_state_e              state_q, state_d;
  logic [GrantWidth-1:0]   grant_q, grant_d;
  logic [GrantWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic                    busy_q, busy_d;
  logic [NumRequesters-1:0] tready_q, tready_d;

  logic                    push_c;
  logic                    beat_last_c;
  logic                    buf_not_full_next_c;
  logic [TIdWidth-1:0]     tid_sel_c;
  logic [PayloadWidth-1:0] push_payload_c;
  logic [PayloadWidth-1:0] head_payload;

  // Only the granted source ever sees ready, so any handshake is its beat.
  assign push_c      = |(s_axis_tvalid_i & tready_q);
  assign beat_last_c = s_axis_tlast_i[grant_q];

  assign tid_sel_c = (TidOverride != 0) ? TIdWidth'(grant_q)
                                        : s_axis_tid_i[32'(grant_q)*TIdWidth +: TIdWidth];

  assign push_payload_c = {s_axis_tdata_i[32'(grant_q)*TDataWidth +: TDataWidth],
                           beat_last_c,
                           tid_sel_c,
                           s_axis_tdest_i[32'(grant_q)*TDestWidth +: TDestWidth]};

  // Arbitration and packet lock; ready is precomputed for the next cycle.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    busy_d   = busy_q;
    tready_d = '0;
    unique case (state_q)
      ArbStateIdle: begin
        if (|s_axis_tvalid_i) begin
          grant_d = GrantWidth'(rr_pick(MaxRequesters'(s_axis_tvalid_i),
                                        MaxGrantWidth'(rr_ptr_q), NumRequesters));
          busy_d  = 1'b1;
          state_d = ArbStateLocked;
        end
      end
      ArbStateLocked: begin
        if (push_c && beat_last_c) begin
          state_d  = ArbStateIdle;
          busy_d   = 1'b0;
          rr_ptr_d = (32'(grant_q) == NumRequesters - 1) ? '0
                                                         : grant_q + GrantWidth'(1);
        end
      end
      default: state_d = ArbStateIdle;
    endcase
    if ((state_d == ArbStateLocked) && buf_not_full_next_c) begin
      tready_d[grant_d] = 1'b1;
    end
  end

  always_ff @(posedge clk_m_axis_i) begin
    if (rst_m_axis_i) begin
      state_q  <= ArbStateIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      tready_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      tready_q <= tready_d;
    end
  end

  assign s_axis_tready_o = tready_q;
  assign grant_o         = grant_q;
  assign busy_o          = busy_q;

  axis_skid_buffer #(
    .Width (PayloadWidth)
  ) u_skid (
    .clk             (clk_m_axis_i),
    .rst             (rst_m_axis_i),
    .push            (push_c),
    .push_data       (push_payload_c),
    .not_full_next_c (buf_not_full_next_c),
    .out_ready       (m_axis_tready_i),
    .out_valid       (m_axis_tvalid_o),
    .out_data        (head_payload)
  );

  assign {m_axis_tdata_o, m_axis_tlast_o, m_axis_tid_o, m_axis_tdest_o} = head_payload;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: behavioural sources feed the DUT and
// a monitor records delivered beats for comparison against hand-built streams.
module tb_axis_packet_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int IW = 8;
  localparam int EW = 8;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   s_valid;
  logic [NR-1:0]   s_ready;
  logic [NR*DW-1:0] s_data;
  logic [NR-1:0]   s_last;
  logic [NR*IW-1:0] s_tid;
  logic [NR*EW-1:0] s_dest;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic [EW-1:0]   m_tdest;
  logic [1:0]      grant;
  logic            busy;

  logic [NR-1:0]   o_s_ready;
  logic            o_m_valid;
  logic [DW-1:0]   o_m_tdata;
  logic            o_m_tlast;
  logic [IW-1:0]   o_m_tid;
  logic [EW-1:0]   o_m_tdest;
  logic [1:0]      o_grant;
  logic            o_busy;

  axis_packet_arbiter #(
    .NumRequesters(NR), .TDataWidth(DW), .TIdWidth(IW), .TDestWidth(EW), .TidOverride(0)
  ) dut (
    .clk_m_axis_i(clk), .rst_m_axis_i(rst),
    .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready), .s_axis_tdata_i(s_data),
    .s_axis_tlast_i(s_last), .s_axis_tid_i(s_tid), .s_axis_tdest_i(s_dest),
    .m_axis_tvalid_o(m_valid), .m_axis_tready_i(m_ready), .m_axis_tdata_o(m_tdata),
    .m_axis_tlast_o(m_tlast), .m_axis_tid_o(m_tid), .m_axis_tdest_o(m_tdest),
    .grant_o(grant), .busy_o(busy)
  );

  axis_packet_arbiter #(
    .NumRequesters(NR), .TDataWidth(DW), .TIdWidth(IW), .TDestWidth(EW), .TidOverride(1)
  ) dut_ovr (
    .clk_m_axis_i(clk), .rst_m_axis_i(rst),
    .s_axis_tvalid_i(s_valid), .s_axis_tready_o(o_s_ready), .s_axis_tdata_i(s_data),
    .s_axis_tlast_i(s_last), .s_axis_tid_i(s_tid), .s_axis_tdest_i(s_dest),
    .m_axis_tvalid_o(o_m_valid), .m_axis_tready_i(m_ready), .m_axis_tdata_o(o_m_tdata),
    .m_axis_tlast_o(o_m_tlast), .m_axis_tid_o(o_m_tid), .m_axis_tdest_o(o_m_tdest),
    .grant_o(o_grant), .busy_o(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source model: per-requester beat lists consumed on handshake.
  logic [DW-1:0] src_data [NR][8];
  logic          src_last [NR][8];
  logic [IW-1:0] src_tid  [NR][8];
  int            src_len  [NR];
  int            src_pos  [NR];
  logic [NR-1:0] hold;

  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];
  logic [IW-1:0] obs_tid[$];
  logic [IW-1:0] obs_otid[$];
  logic [EW-1:0] obs_dest[$];
  int            obs_cyc[$];

  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  logic [EW-1:0] exp_dest[$];

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc, in_cnt, out_cnt, max_occ;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      int p;
      p = (src_pos[k] < src_len[k]) ? src_pos[k] : 0;
      s_valid[k]          = !hold[k] && (src_pos[k] < src_len[k]);
      s_data[k*DW +: DW]  = src_data[k][p];
      s_last[k]           = src_last[k][p];
      s_tid[k*IW +: IW]   = src_tid[k][p];
      s_dest[k*EW +: EW]  = EW'(k);
    end
  endtask

  task automatic add_beat(input int k, input logic [DW-1:0] d, input logic l, input logic [IW-1:0] t);
    src_data[k][src_len[k]] = d;
    src_last[k][src_len[k]] = l;
    src_tid[k][src_len[k]]  = t;
    src_len[k]++;
  endtask

  task automatic add_exp(input logic [DW-1:0] d, input logic l, input logic [EW-1:0] e);
    exp_data.push_back(d);
    exp_last.push_back(l);
    exp_dest.push_back(e);
  endtask

  task automatic cycle();
    logic [NR-1:0] acc;
    acc = rst ? '0 : (s_valid & s_ready);
    if (!rst && m_valid && m_ready) begin
      obs_data.push_back(m_tdata);
      obs_last.push_back(m_tlast);
      obs_tid.push_back(m_tid);
      obs_otid.push_back(o_m_tid);
      obs_dest.push_back(m_tdest);
      obs_cyc.push_back(cyc);
      out_cnt++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) src_pos[k]++;
    end
    in_cnt += $countones(acc);
    if (in_cnt - out_cnt > max_occ) max_occ = in_cnt - out_cnt;
    cyc++;
    drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      src_len[k] = 0;
      src_pos[k] = 0;
      hold[k]    = 1'b0;
    end
    drive();
    repeat (n) cycle();
    rst = 1'b0;
    obs_data.delete(); obs_last.delete(); obs_tid.delete();
    obs_otid.delete(); obs_dest.delete(); obs_cyc.delete();
    exp_data.delete(); exp_last.delete(); exp_dest.delete();
    cyc = 0; in_cnt = 0; out_cnt = 0; max_occ = 0;
  endtask

  task automatic check_stream(input string tag);
    check($sformatf("%s count", tag), 64'(obs_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++) begin
      check($sformatf("%s data[%0d]", tag, i), obs_data[i], exp_data[i]);
      check($sformatf("%s last[%0d]", tag, i), 64'(obs_last[i]), 64'(exp_last[i]));
      check($sformatf("%s dest[%0d]", tag, i), 64'(obs_dest[i]), 64'(exp_dest[i]));
    end
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b1; s_valid = '0; s_data = '0; s_last = '0; s_tid = '0; s_dest = '0;
    cyc = 0; in_cnt = 0; out_cnt = 0; max_occ = 0;

    // Reset state
    do_reset(2);
    check("rst m_valid", 64'(m_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst grant", 64'(grant), 64'd0);
    check("rst s_ready", 64'(s_ready), 64'd0);
    check("rst m_tdata", m_tdata, 64'd0);

    // Requesters 0 and 2, 3-beat packets each
    for (int j = 0; j < 3; j++) begin
      add_beat(0, 64'h10 + 64'(j), j == 2, 8'h00);
      add_beat(2, 64'h20 + 64'(j), j == 2, 8'h02);
    end
    for (int j = 0; j < 3; j++) add_exp(64'h10 + 64'(j), j == 2, 8'd0);
    for (int j = 0; j < 3; j++) add_exp(64'h20 + 64'(j), j == 2, 8'd2);
    drive();
    cycle();
    check("t2 grant0", 64'(grant), 64'd0);
    check("t2 busy0", 64'(busy), 64'd1);
    check("t2 ready0", 64'(s_ready), 64'h1);
    repeat (3) cycle();
    check("t2 idle busy", 64'(busy), 64'd0);
    check("t2 idle ready", 64'(s_ready), 64'h0);
    cycle();
    check("t2 grant2", 64'(grant), 64'd2);
    check("t2 busy2", 64'(busy), 64'd1);
    repeat (8) cycle();
    check_stream("t2");
    check("t2 beat gap", 64'(obs_cyc[1] - obs_cyc[0]), 64'd1);
    check("t2 pkt gap", 64'(obs_cyc[3] - obs_cyc[2]), 64'd2);

    // All four requesters, single-beat packets, round-robin order
    do_reset(1);
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < NR; k++) begin
        add_beat(k, 64'h100 * 64'(k) + 64'(j), 1'b1, (k == 2) ? 8'hAB : 8'hC0 + 8'(k));
      end
    end
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < NR; k++) add_exp(64'h100 * 64'(k) + 64'(j), 1'b1, 8'(k));
    end
    drive();
    repeat (20) cycle();
    check_stream("t3");
    check("t3 tid pass", 64'(obs_tid[2]), 64'hAB);
    check("t3 tid pass k3", 64'(obs_tid[3]), 64'hC3);
    check("t3 tid ovr k2", 64'(obs_otid[2]), 64'h02);
    check("t3 tid ovr k3", 64'(obs_otid[7]), 64'h03);

    // Backpressure on requester 1
    do_reset(1);
    for (int j = 0; j < 4; j++) begin
      add_beat(1, 64'h40 + 64'(j), j == 3, 8'h01);
      add_exp(64'h40 + 64'(j), j == 3, 8'd1);
    end
    drive();
    cycle();
    m_ready = 1'b0;
    repeat (3) cycle();
    check("t4 ready full", 64'(s_ready), 64'h0);
    check("t4 valid stall", 64'(m_valid), 64'd1);
    check("t4 data stall", m_tdata, 64'h40);
    repeat (2) cycle();
    check("t4 data stable", m_tdata, 64'h40);
    check("t4 busy", 64'(busy), 64'd1);
    m_ready = 1'b1;
    repeat (10) cycle();
    check_stream("t4");
    check("t4 max occupancy", 64'(max_occ), 64'd2);

    // Requester 3 pauses mid-packet while requester 0 waits
    do_reset(1);
    for (int j = 0; j < 4; j++) begin
      add_beat(3, 64'h50 + 64'(j), j == 3, 8'h03);
      add_exp(64'h50 + 64'(j), j == 3, 8'd3);
    end
    add_beat(0, 64'h60, 1'b1, 8'h00);
    add_exp(64'h60, 1'b1, 8'd0);
    hold[0] = 1'b1;
    drive();
    cycle();
    hold[0] = 1'b0;
    drive();
    repeat (2) cycle();
    hold[3] = 1'b1;
    drive();
    repeat (5) cycle();
    check("t5 grant held", 64'(grant), 64'd3);
    check("t5 busy held", 64'(busy), 64'd1);
    check("t5 ready held", 64'(s_ready), 64'h8);
    check("t5 no interleave", 64'(obs_data.size()), 64'd2);
    hold[3] = 1'b0;
    drive();
    repeat (3) cycle();
    check("t5 grant next", 64'(grant), 64'd0);
    repeat (6) cycle();
    check_stream("t5");

    // Reset pulse during beat 2 of a 4-beat packet
    do_reset(1);
    for (int j = 0; j < 4; j++) add_beat(0, 64'h70 + 64'(j), j == 3, 8'h00);
    drive();
    repeat (2) cycle();
    do_reset(1);
    check("t6 m_valid", 64'(m_valid), 64'd0);
    check("t6 busy", 64'(busy), 64'd0);
    check("t6 grant", 64'(grant), 64'd0);
    check("t6 ready", 64'(s_ready), 64'h0);
    for (int j = 0; j < 3; j++) begin
      add_beat(1, 64'h80 + 64'(j), j == 2, 8'h01);
      add_exp(64'h80 + 64'(j), j == 2, 8'd1);
    end
    drive();
    cycle();
    check("t6 grant1", 64'(grant), 64'd1);
    repeat (8) cycle();
    check_stream("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one tile AXI-Stream initiator interface (the m_axis side feeding the network interface target port) among NumRequesters PE-side sources.
- Grant is held for a whole packet, from first beat to the accepted beat with tlast, so packets never interleave on the NI.
- Output is registered through a 2-entry skid buffer, so the NI-facing timing is decoupled from the requesters.

Parameters:
- NumRequesters, 4, number of AXI-Stream sources (2..16).
- TDataWidth, 64, tdata width in bits.
- TIdWidth, 8, tid width; must be >= bitsize(NumRequesters) when TidOverride != 0.
- TDestWidth, 8, tdest width.
- TidOverride, 0, nonzero: output tid = granted requester index, zero-extended; 0: tid passes through.

Ports:
- clk_m_axis_i  in  1  clock, shared by all requesters and the NI target.
- rst_m_axis_i  in  1  synchronous, active-high reset.
- s_axis_tvalid_i  in  NumRequesters  per-requester valid.
- s_axis_tready_o  out  NumRequesters  per-requester ready.
- s_axis_tdata_i  in  NumRequesters*TDataWidth  packed; requester k at [k*TDataWidth +: TDataWidth].
- s_axis_tlast_i  in  NumRequesters  per-requester last.
- s_axis_tid_i  in  NumRequesters*TIdWidth  packed tid.
- s_axis_tdest_i  in  NumRequesters*TDestWidth  packed tdest.
- m_axis_tvalid_o  out  1  to NI target.
- m_axis_tready_i  in  1  from NI target.
- m_axis_tdata_o  out  TDataWidth  output data.
- m_axis_tlast_o  out  1  output last.
- m_axis_tid_o  out  TIdWidth  output tid.
- m_axis_tdest_o  out  TDestWidth  output tdest.
- grant_o  out  bitsize(NumRequesters)  index of the current or last granted requester.
- busy_o  out  1  high while a packet is locked.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, grant_o=0, busy_o=0, s_axis_tready_o=0, skid buffer emptied, m_axis_tvalid_o=0. m_axis data outputs are 0.
- Reset asserted mid-packet drops the in-flight packet and any buffered beats. No partial packet is completed after reset.
- FSM has 2 states:
  - IDLE: s_axis_tready_o=0. If any tvalid is high, pick the first set bit searching from rr_ptr upward with wrap-around, register it into grant_o, set busy_o, and go to LOCKED on the next cycle. Arbitration costs exactly 1 cycle.
  - LOCKED: s_axis_tready_o[grant] = skid buffer not full. All other ready bits are 0. A beat is accepted when tvalid[grant] && tready[grant].
  - On an accepted beat with tlast=1: go to IDLE, rr_ptr = grant+1 mod NumRequesters, clear busy_o.
- A requester that drops tvalid mid-packet keeps the grant. The arbiter waits indefinitely; there is no timeout.
- Single-beat packet: one LOCKED cycle if the buffer has space, then IDLE.
- Fairness: after serving k, requester k has the lowest priority. Any continuously requesting source waits at most NumRequesters-1 packets.
- A tvalid raised in the same cycle as the IDLE decision is considered in that decision.
- Skid buffer (2 entries):
  - Outputs are driven from the head register.
  - Latency: 1 cycle from accepted input beat to m_axis_tvalid_o.
  - Sustains 1 beat/cycle with m_axis_tready_i held high.
  - Full when 2 entries are held; ready toward the requester is registered (not-full of the next state).
- Simultaneous push and pop keeps occupancy unchanged. Pop with an empty buffer never occurs, since tvalid is 0 when empty.
- m_axis outputs are stable while tvalid=1 and tready=0 (AXI-Stream rule).
- Throughput: packets of N beats from alternating requesters take N+1 cycles each, when not backpressured.

Decomposition:
- Shared header axis_arbiter_defs.vh holds:
  - state encodings (ArbStateIdle=1'b0, ArbStateLocked=1'b1);
  - the packed-slice helper macro;
  - reuse of bitsize() from common_functions.vh.
- Sub-module axis_skid_buffer (2-entry, parameter Width = TDataWidth+1+TIdWidth+TDestWidth). It is reusable at other NI boundaries.
- Round-robin pick is a function in the header, not a module.

Test Plan:
- Reset then requesters 0 and 2 each send a 3-beat packet (tdata 0x10..0x12, 0x20..0x22) at t=0, tready=1:
  - output is 0x10,0x11,0x12 (tlast on 0x12), then 0x20,0x21,0x22;
  - grant_o goes 0 then 2;
  - there is one idle cycle between the packets.
- All 4 requesters continuously send 1-beat packets (tdest = index) -> output tdest sequence 0,1,2,3,0,1,… with no starvation.
- Requester 1 sends 4 beats, m_axis_tready_i low for cycles 2–5 -> at most 2 beats are buffered, s_axis_tready_o[1]=0 while full, and all 4 beats arrive in order with no duplicates.
- Requester 3 deasserts tvalid for 5 cycles mid-packet while requester 0 is valid -> grant stays 3 and no beat from 0 appears until 3's tlast is accepted.
- TidOverride=1: requester 2 sends tid 0xAB -> m_axis_tid_o=0x02.
- rst_m_axis_i pulsed for 1 cycle during beat 2 of a 4-beat packet -> next cycle m_axis_tvalid_o=0, busy_o=0, grant_o=0, and a fresh packet from requester 1 is delivered intact.
